cpu_clk_ctrl: RTL

Run/halt/single-step sequencer for the CPU clock domain. It sits downstream of the cpuclk clock wizard and is clocked by its clk_out1. It first waits for the wizard to report a stable lock, then holds the CPU in reset. After that it gates CPU progress with a registered clock enable, driven by run, halt and N-step requests from the debug/board-IO logic. It never gates the clock net itself; the CPU uses cpu_ce as a synchronous enable.

---
 rtl/cpu_clk_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl
//
// Run/halt/single-step sequencer for the CPU clock domain. It is clocked by the
// CPU clock wizard output and controls CPU progress only through a registered
// clock enable. The clock net is never gated.
//
// Sequence after rst_n is released:
//   WAIT_LOCK : wait until `locked` has been high for LOCK_WAIT consecutive edges
//   RST_HOLD  : keep the CPU in reset for RST_HOLD cycles
//   HALTED    : CPU out of reset, cpu_ce low, waiting for run/step requests
//   RUN       : cpu_ce high every cycle until halt_req
//   STEP      : cpu_ce high for exactly the loaded number of cycles
// If `locked` drops in any state after WAIT_LOCK, the block returns to
// WAIT_LOCK and the CPU goes back into reset.
//
// Ports:
//   clk         in   CPU clock; all logic uses the rising edge
//   rst_n       in   synchronous, active-low reset
//   locked      in   clock wizard lock indicator, synchronous to clk
//   run_req     in   start free-running (level or pulse)
//   halt_req    in   stop enabling (level or pulse)
//   step_req    in   single-cycle pulse: run step_num enabled cycles
//   step_num    in   [STEP_W] step count sampled with step_req; 0 acts as 1
//   cpu_ce      out  registered CPU clock enable
//   cpu_rst_n   out  registered active-low CPU reset
//   state       out  [3] current state (WAIT_LOCK=0 .. STEP=4)
//   steps_left  out  [STEP_W] remaining step cycles
//   cycle_cnt   out  [CNT_W] number of cycles with cpu_ce=1, wraps silently
// -----------------------------------------------------------------------------
module cpu_clk_ctrl #(
   parameter int LOCK_WAIT = 16,
   parameter int RST_HOLD  = 8,
   parameter int STEP_W    = 8,
   parameter int CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              locked,
   input  logic              run_req,
   input  logic              halt_req,
   input  logic              step_req,
   input  logic [STEP_W-1:0] step_num,
   output logic              cpu_ce,
   output logic              cpu_rst_n,
   output logic [2:0]        state,
   output logic [STEP_W-1:0] steps_left,
   output logic [CNT_W-1:0]  cycle_cnt
);

   // State codes are visible on the `state` port, so the encoding is fixed.
   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_RST_HOLD  = 3'd1,
      ST_HALTED    = 3'd2,
      ST_RUN       = 3'd3,
      ST_STEP      = 3'd4
   } state_t;

   // Counters only need to reach LOCK_WAIT-1 / RST_HOLD-1.
   localparam int LOCK_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
   localparam int HOLD_W = (RST_HOLD  > 1) ? $clog2(RST_HOLD)  : 1;

   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_WAIT - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
   localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t              r_state;
   logic [LOCK_W-1:0]   r_lock_cnt;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic [STEP_W-1:0]   r_steps_left;
   logic                r_cpu_ce;
   logic                r_cpu_rst_n;
   logic [CNT_W-1:0]    r_cycle_cnt;

   // ---------------------------------------------------------------------------
   // Next-state values
   // ---------------------------------------------------------------------------
   state_t              w_state_nxt;
   logic [LOCK_W-1:0]   w_lock_cnt_nxt;
   logic [HOLD_W-1:0]   w_hold_cnt_nxt;
   logic [STEP_W-1:0]   w_steps_left_nxt;
   logic                w_cycle_clr;
   logic                w_cpu_ce_nxt;
   logic                w_cpu_rst_n_nxt;
   logic [STEP_W-1:0]   w_step_load;

   // A zero step count still executes one cycle.
   assign w_step_load = (step_num == '0) ? STEP_ONE : step_num;

   // ---------------------------------------------------------------------------
   // Next-state / datapath logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves one unassigned, which would otherwise infer a latch.
      w_state_nxt      = r_state;
      w_lock_cnt_nxt   = '0;
      w_hold_cnt_nxt   = r_hold_cnt;
      w_steps_left_nxt = r_steps_left;
      w_cycle_clr      = 1'b0;

      case (r_state)
         ST_WAIT_LOCK: begin
            w_steps_left_nxt = '0;
            // lock_cnt counts the current run of consecutive locked cycles;
            // it falls back to zero (the default) whenever locked is low.
            if (locked) begin
               if (r_lock_cnt == LOCK_LAST) begin
                  w_state_nxt    = ST_RST_HOLD;
                  w_hold_cnt_nxt = '0;
                  w_cycle_clr    = 1'b1;
               end else begin
                  w_lock_cnt_nxt = r_lock_cnt + LOCK_W'(1);
               end
            end
         end

         ST_RST_HOLD: begin
            if (r_hold_cnt == HOLD_LAST) begin
               w_state_nxt = ST_HALTED;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
            end
         end

         ST_HALTED: begin
            // Priority: halt > step > run. A halt simply keeps us here.
            if (halt_req) begin
               w_state_nxt = ST_HALTED;
            end else if (step_req) begin
               w_state_nxt      = ST_STEP;
               w_steps_left_nxt = w_step_load;
            end else if (run_req) begin
               w_state_nxt = ST_RUN;
            end
         end

         ST_RUN: begin
            if (halt_req) begin
               w_state_nxt = ST_HALTED;
            end
         end

         ST_STEP: begin
            // cpu_ce is high for every cycle spent in STEP, so the count
            // decrements on every edge here; the last one returns to HALTED.
            if (halt_req || (r_steps_left == STEP_ONE)) begin
               w_state_nxt      = ST_HALTED;
               w_steps_left_nxt = '0;
            end else begin
               w_steps_left_nxt = r_steps_left - STEP_ONE;
            end
         end

         default: begin
            // Unused codes 5-7 recover through WAIT_LOCK.
            w_state_nxt      = ST_WAIT_LOCK;
            w_steps_left_nxt = '0;
            w_hold_cnt_nxt   = '0;
         end
      endcase

      // Losing lock outranks every request: drop back and re-qualify.
      if (!locked && (r_state != ST_WAIT_LOCK)) begin
         w_state_nxt      = ST_WAIT_LOCK;
         w_steps_left_nxt = '0;
         w_lock_cnt_nxt   = '0;
         w_cycle_clr      = 1'b0;
      end
   end

   // Enable and CPU reset are pure functions of the state being entered, so
   // registering them keeps them aligned with `state` on the same edge.
   assign w_cpu_ce_nxt    = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_STEP);
   assign w_cpu_rst_n_nxt = w_cpu_ce_nxt || (w_state_nxt == ST_HALTED);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: the reset here is synchronous -- it is sampled on the clock edge
      // like any other input, so rst_n does not appear in the sensitivity list.
      if (!rst_n) begin
         r_state      <= ST_WAIT_LOCK;
         r_lock_cnt   <= '0;
         r_hold_cnt   <= '0;
         r_steps_left <= '0;
         r_cpu_ce     <= 1'b0;
         r_cpu_rst_n  <= 1'b0;
         r_cycle_cnt  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         r_state      <= w_state_nxt;
         r_lock_cnt   <= w_lock_cnt_nxt;
         r_hold_cnt   <= w_hold_cnt_nxt;
         r_steps_left <= w_steps_left_nxt;
         r_cpu_ce     <= w_cpu_ce_nxt;
         r_cpu_rst_n  <= w_cpu_rst_n_nxt;
         // Counts cycles in which the CPU actually advanced (registered
         // cpu_ce), wrapping without a flag. Entry to RST_HOLD restarts it.
         if (w_cycle_clr) begin
            r_cycle_cnt <= '0;
         end else if (r_cpu_ce) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign cpu_ce     = r_cpu_ce;
   assign cpu_rst_n  = r_cpu_rst_n;
   assign state      = r_state;
   assign steps_left = r_steps_left;
   assign cycle_cnt  = r_cycle_cnt;

endmodule
